// File: rtl/slot_arbiter.sv
// Garage door and slot-pool arbiter: grants entry/exit requests round-robin,
// hands entering cars the lowest free slot and times the door open window.
module slot_arbiter #(
    parameter int N_SLOTS     = 4,
    parameter int DOOR_CYCLES = 2000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_in,
    input  logic               req_out,
    input  logic [1:0]         out_slot,
    output logic               grant_in,
    output logic               grant_out,
    output logic               door_open,
    output logic [1:0]         alloc_slot,
    output logic [N_SLOTS-1:0] occupancy,
    output logic [2:0]         free_count,
    output logic [1:0]         near_slot,
    output logic               full,
    output logic               err_exit
);

    localparam int TIMER_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(DOOR_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, OPEN_IN, OPEN_OUT, CLOSE} state_t;

    state_t               state, next_state;
    logic [TIMER_W-1:0]   timer;
    logic [1:0]           exit_slot;
    logic                 last_out;
    logic [2:0]           occ_cnt;
    logic [3:0]           occ_pad;
    logic                 exit_valid;
    logic                 take_in, take_out, bad_exit, release_exit;
    logic [N_SLOTS-1:0]   near_mask, exit_mask;

    always_comb begin
        occ_cnt = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            occ_cnt = occ_cnt + 3'(occupancy[i]);
        end
        near_slot = '0;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if (!occupancy[i]) near_slot = 2'(i);
        end
    end

    assign free_count = 3'(N_SLOTS) - occ_cnt;
    assign full       = (free_count == 3'd0);
    assign occ_pad    = 4'(occupancy);
    // Slot indices beyond N_SLOTS read as empty and so raise err_exit.
    assign exit_valid = occ_pad[out_slot];
    assign near_mask  = N_SLOTS'(1) << near_slot;
    assign exit_mask  = N_SLOTS'(1) << exit_slot;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state   = state;
        take_in      = 1'b0;
        take_out     = 1'b0;
        bad_exit     = 1'b0;
        release_exit = 1'b0;
        door_open    = 1'b0;
        case (state)
            IDLE: begin
                bad_exit = req_out && !exit_valid;
                if (req_in && !full && req_out && exit_valid) begin
                    take_out = !last_out;
                    take_in  = last_out;
                end else if (req_in && !full) begin
                    take_in = 1'b1;
                end else if (req_out && exit_valid) begin
                    take_out = 1'b1;
                end
                if (take_in)  next_state = OPEN_IN;
                if (take_out) next_state = OPEN_OUT;
            end
            OPEN_IN, OPEN_OUT: begin
                door_open = 1'b1;
                if (timer == TIMER_LAST) begin
                    next_state   = CLOSE;
                    release_exit = (state == OPEN_OUT);
                end
            end
            CLOSE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occupancy  <= '0;
            alloc_slot <= '0;
            timer      <= '0;
            exit_slot  <= '0;
            last_out   <= 1'b0;
            grant_in   <= 1'b0;
            grant_out  <= 1'b0;
            err_exit   <= 1'b0;
        end else begin
            grant_in  <= take_in;
            grant_out <= take_out;
            err_exit  <= bad_exit;
            if (take_in) begin
                alloc_slot <= near_slot;
                occupancy  <= occupancy | near_mask;
                last_out   <= 1'b0;
                timer      <= '0;
            end else if (take_out) begin
                exit_slot <= out_slot;
                last_out  <= 1'b1;
                timer     <= '0;
            end else if (door_open) begin
                timer <= timer + TIMER_W'(1);
                // The vacated slot is only returned to the pool once the door window ends.
                if (release_exit) occupancy <= occupancy & ~exit_mask;
            end
        end
    end

endmodule

// File: tb/tb_slot_arbiter.sv
// Directed bench for slot_arbiter with a short door window (DOOR_CYCLES = 4).
module tb_slot_arbiter;

    localparam int DC = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_in = 1'b0;
    logic       req_out = 1'b0;
    logic [1:0] out_slot = 2'd0;
    logic       grant_in, grant_out, door_open, full, err_exit;
    logic [1:0] alloc_slot, near_slot;
    logic [3:0] occupancy;
    logic [2:0] free_count;

    int tests = 0;
    int fails = 0;

    slot_arbiter #(.N_SLOTS(4), .DOOR_CYCLES(DC)) dut (
        .clk(clk), .rst(rst), .req_in(req_in), .req_out(req_out),
        .out_slot(out_slot), .grant_in(grant_in), .grant_out(grant_out),
        .door_open(door_open), .alloc_slot(alloc_slot), .occupancy(occupancy),
        .free_count(free_count), .near_slot(near_slot), .full(full),
        .err_exit(err_exit)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        req_in  = 1'b0;
        req_out = 1'b0;
        out_slot = 2'd0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // Steps edge by edge until a grant appears; cyc = edges waited, -1 on timeout.
    task automatic wait_grant(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 50; i++) begin
            @(posedge clk);
            #1;
            if (grant_in || grant_out) begin
                cyc = i;
                break;
            end
        end
    endtask

    // One entry transaction, returning to IDLE afterwards.
    task automatic do_entry(output int cyc);
        req_in = 1'b1;
        wait_grant(cyc);
        req_in = 1'b0;
        repeat (DC + 1) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int cyc;
        int door_cnt;
        rst = 1'b0;
        #7;
        tests++;
        if ({grant_in, grant_out, door_open, err_exit, full} !== 5'b0 || occupancy !== 4'b0 ||
            free_count !== 3'd4 || near_slot !== 2'd0 || alloc_slot !== 2'd0) begin
            fails++;
            $display("FAIL reset_state: occ=%b free=%0d near=%0d alloc=%0d gi=%b go=%b door=%b err=%b full=%b, need occ=0000 free=4 rest 0",
                     occupancy, free_count, near_slot, alloc_slot, grant_in, grant_out, door_open, err_exit, full);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        req_in = 1'b1;
        wait_grant(cyc);
        req_in = 1'b0;
        tests++;
        if (cyc !== 1 || grant_in !== 1'b1 || door_open !== 1'b1) begin
            fails++;
            $display("FAIL first_grant: cyc=%0d gi=%b door=%b, need cyc=1 gi=1 door=1", cyc, grant_in, door_open);
        end
        tests++;
        if (alloc_slot !== 2'd0 || occupancy !== 4'b0001 || free_count !== 3'd3) begin
            fails++;
            $display("FAIL first_alloc: alloc=%0d occ=%b free=%0d, need 0 0001 3", alloc_slot, occupancy, free_count);
        end
        door_cnt = 1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (door_open) door_cnt++;
            if (i == 0) begin
                tests++;
                if (grant_in !== 1'b0) begin
                    fails++;
                    $display("FAIL grant_pulse_width: gi=%b one cycle later, need 0", grant_in);
                end
            end
        end
        tests++;
        if (door_cnt !== DC) begin
            fails++;
            $display("FAIL door_window: open cycles=%0d, need %0d", door_cnt, DC);
        end
    endtask

    task automatic test_fill();
        int cyc;
        int gcnt;
        int dcnt;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            do_entry(cyc);
            tests++;
            if (cyc !== 1 || alloc_slot !== 2'(k)) begin
                fails++;
                $display("FAIL fill_alloc%0d: cyc=%0d alloc=%0d, need cyc=1 alloc=%0d", k, cyc, alloc_slot, k);
            end
        end
        tests++;
        if (occupancy !== 4'b1111 || full !== 1'b1 || near_slot !== 2'd0 || free_count !== 3'd0) begin
            fails++;
            $display("FAIL fill_full: occ=%b full=%b near=%0d free=%0d, need 1111 1 0 0", occupancy, full, near_slot, free_count);
        end
        req_in = 1'b1;
        gcnt = 0;
        dcnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (grant_in || grant_out || err_exit) gcnt++;
            if (door_open) dcnt++;
        end
        tests++;
        if (gcnt !== 0 || dcnt !== 0) begin
            fails++;
            $display("FAIL full_blocks_entry: grants/errs=%0d door cycles=%0d, need 0 0", gcnt, dcnt);
        end
    endtask

    // Continues from a full garage with req_in still held.
    task automatic test_exit_while_full();
        int cyc;
        req_out = 1'b1;
        out_slot = 2'd2;
        wait_grant(cyc);
        req_out = 1'b0;
        tests++;
        if (cyc !== 1 || grant_out !== 1'b1 || grant_in !== 1'b0 || door_open !== 1'b1) begin
            fails++;
            $display("FAIL exit_first: cyc=%0d go=%b gi=%b door=%b, need 1 1 0 1", cyc, grant_out, grant_in, door_open);
        end
        repeat (DC - 1) @(posedge clk);
        #1;
        tests++;
        if (occupancy !== 4'b1111 || full !== 1'b1) begin
            fails++;
            $display("FAIL exit_hold: occ=%b full=%b before window end, need 1111 1", occupancy, full);
        end
        @(posedge clk);
        #1;
        tests++;
        if (occupancy !== 4'b1011 || full !== 1'b0 || near_slot !== 2'd2 || door_open !== 1'b0) begin
            fails++;
            $display("FAIL exit_release: occ=%b full=%b near=%0d door=%b, need 1011 0 2 0", occupancy, full, near_slot, door_open);
        end
        wait_grant(cyc);
        req_in = 1'b0;
        tests++;
        if (cyc !== 2 || grant_in !== 1'b1 || alloc_slot !== 2'd2 || occupancy !== 4'b1111 || full !== 1'b1) begin
            fails++;
            $display("FAIL refill: cyc=%0d gi=%b alloc=%0d occ=%b full=%b, need 2 1 2 1111 1", cyc, grant_in, alloc_slot, occupancy, full);
        end
        repeat (DC + 1) @(posedge clk);
    endtask

    task automatic test_bad_exit();
        int cyc;
        int ecnt;
        int other;
        do_reset();
        do_entry(cyc);
        do_entry(cyc);
        req_out = 1'b1;
        out_slot = 2'd3;
        ecnt = 0;
        other = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (err_exit) ecnt++;
            if (grant_out || grant_in || door_open) other++;
        end
        req_out = 1'b0;
        @(posedge clk);
        #1;
        tests++;
        if (ecnt !== 5 || other !== 0) begin
            fails++;
            $display("FAIL bad_exit_err: err pulses=%0d grant/door cycles=%0d, need 5 0", ecnt, other);
        end
        tests++;
        if (occupancy !== 4'b0011 || err_exit !== 1'b0) begin
            fails++;
            $display("FAIL bad_exit_state: occ=%b err=%b after drop, need 0011 0", occupancy, err_exit);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        logic [3:0] kinds;
        int errs;
        do_reset();
        do_entry(cyc);
        do_entry(cyc);
        req_in = 1'b1;
        req_out = 1'b1;
        out_slot = 2'd0;
        errs = 0;
        for (int g = 0; g < 4; g++) begin
            wait_grant(cyc);
            kinds[g] = grant_out;
            if (err_exit) errs++;
            if (g > 0) begin
                tests++;
                if (cyc !== DC + 2) begin
                    fails++;
                    $display("FAIL grant_spacing%0d: cycles=%0d, need %0d", g, cyc, DC + 2);
                end
            end
            if (grant_out) out_slot = (out_slot == 2'd0) ? 2'd1 : 2'd0;
        end
        req_in = 1'b0;
        req_out = 1'b0;
        tests++;
        if (kinds !== 4'b0101 || errs !== 0) begin
            fails++;
            $display("FAIL round_robin: grant_out per grant (g3..g0)=%b errs=%0d, need 0101 0", kinds, errs);
        end
        repeat (DC + 1) @(posedge clk);
        #1;
        tests++;
        if (occupancy !== 4'b0011) begin
            fails++;
            $display("FAIL rr_final_occ: occ=%b, need 0011", occupancy);
        end
    endtask

    task automatic test_async_reset();
        int cyc;
        do_reset();
        req_in = 1'b1;
        wait_grant(cyc);
        req_in = 1'b0;
        #1 rst = 1'b0;
        #1;
        tests++;
        if (grant_in !== 1'b0 || door_open !== 1'b0 || occupancy !== 4'b0 || free_count !== 3'd4) begin
            fails++;
            $display("FAIL async_reset: gi=%b door=%b occ=%b free=%0d, need 0 0 0000 4", grant_in, door_open, occupancy, free_count);
        end
        #3 rst = 1'b1;
        req_in = 1'b1;
        wait_grant(cyc);
        req_in = 1'b0;
        tests++;
        if (cyc < 1 || grant_in !== 1'b1 || alloc_slot !== 2'd0 || occupancy !== 4'b0001 || free_count !== 3'd3) begin
            fails++;
            $display("FAIL post_reset_entry: cyc=%0d gi=%b alloc=%0d occ=%b free=%0d, need gi=1 0 0001 3",
                     cyc, grant_in, alloc_slot, occupancy, free_count);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_exit_while_full();
        test_bad_exit();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
